// File: rtl/booth_pkg.sv
// Shared constants and types for the radix-4 Booth partial-product accumulator.
package booth_pkg;

    localparam int PP_W           = 36;
    localparam int RES_W          = 64;
    localparam int NUM_PP_DEFAULT = 17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] TAIL_NONE = 2'b00;
    localparam logic [1:0] TAIL_NEG  = 2'b01;

endpackage

// File: rtl/booth_row_align.sv
// Maps one encoded partial-product row to its 64-bit addend at the row's weight.
module booth_row_align
    import booth_pkg::*;
#(
    parameter int NUM_PP = NUM_PP_DEFAULT
) (
    input  logic [PP_W-1:0]           pp_data_i,
    input  logic [1:0]                pp_tail_i,
    input  logic [$clog2(NUM_PP)-1:0] row_idx_i,
    input  logic                      is_last_i,
    output logic [RES_W-1:0]          aligned_o
);

    localparam int SH_W     = $clog2(RES_W);
    localparam int TAIL_OFS = 2 * (NUM_PP - 1);

    logic [SH_W-1:0]  shift;
    logic [RES_W-1:0] row_ext;
    logic [RES_W-1:0] tail_ext;

    // Rows 1.. carry the previous row's +1 in bits [1:0], so they sit two bits lower.
    always_comb begin
        shift = '0;
        if (row_idx_i != '0) begin
            shift = SH_W'((32'(row_idx_i) - 32'd1) * 2);
        end
    end

    assign row_ext   = RES_W'(pp_data_i) << shift;
    assign tail_ext  = is_last_i ? (RES_W'(pp_tail_i) << TAIL_OFS) : '0;
    assign aligned_o = row_ext + tail_ext;

endmodule

// File: rtl/booth_pp_accum.sv
// Accumulates NUM_PP aligned Booth rows into a 64-bit product on a valid/ready stream.
//   state | meaning
//   IDLE  | acc and row count zero, waiting for row 0
//   ACCUM | rows 1..NUM_PP-1 being summed
//   DONE  | product held on res_data until consumed
module booth_pp_accum
    import booth_pkg::*;
#(
    parameter int NUM_PP = NUM_PP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             pp_valid,
    output logic             pp_ready,
    input  logic [PP_W-1:0]  pp_data,
    input  logic [1:0]       pp_tail,
    input  logic             pp_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RES_W-1:0] res_data,
    output logic             err_seq
);

    localparam int CNT_W = $clog2(NUM_PP);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [RES_W-1:0] acc_q;
    logic [RES_W-1:0] acc_d;
    logic [RES_W-1:0] addend;
    logic             pp_ready_q;
    logic             res_valid_q;
    logic             err_q;
    logic             is_last;
    logic             accept;

    assign is_last = (cnt_q == CNT_W'(NUM_PP - 1));
    assign accept  = pp_valid && pp_ready_q;

    booth_row_align #(
        .NUM_PP(NUM_PP)
    ) u_align (
        .pp_data_i(pp_data),
        .pp_tail_i(pp_tail),
        .row_idx_i(cnt_q),
        .is_last_i(is_last),
        .aligned_o(addend)
    );

    assign acc_d = acc_q + addend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            pp_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else if (clear) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            pp_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc_q <= acc_d;
                        if (pp_last != is_last) begin
                            err_q <= 1'b1;
                        end
                        // The row count alone ends a product; pp_last only flags errors.
                        if (is_last) begin
                            state_q     <= DONE;
                            cnt_q       <= '0;
                            pp_ready_q  <= 1'b0;
                            res_valid_q <= 1'b1;
                        end else begin
                            state_q <= ACCUM;
                            cnt_q   <= cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_q     <= IDLE;
                        acc_q       <= '0;
                        pp_ready_q  <= 1'b1;
                        res_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    acc_q       <= '0;
                    pp_ready_q  <= 1'b1;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign pp_ready  = pp_ready_q;
    assign res_valid = res_valid_q;
    assign res_data  = acc_q;
    assign err_seq   = err_q;

endmodule

// File: doc/booth_pp_accum.md
# booth_pp_accum

Sequential accumulator for the radix-4 Booth multiplier datapath. It receives the 36-bit sign-extension-encoded partial products from the partial-product generator one row per handshake. It aligns each row and adds it into a 64-bit running sum, then presents the modulo-2^64 product on a valid/ready result port. It is the consumer end of the partial-product stream; the generator and Booth encoder sit upstream.

## Interface
Parameters:
- NUM_PP, 17, rows per product; 17 covers a 32x32 product with zero-extended multiplier (row 0 first, row NUM_PP-1 last).

Ports:
- Reset is asynchronous and active-low; one clock domain.
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous abort; returns to IDLE and discards the partial sum
- pp_valid  in  1  row present
- pp_ready  out  1  row accepted when pp_valid && pp_ready
- pp_data  in  36  partial-product row, in generator encoding
- pp_tail  in  2  the row's own tail-out bits (2'b01 if the digit was negated, else 2'b00); used only on the last row
- pp_last  in  1  sender marks row NUM_PP-1
- res_valid  out  1  product available
- res_ready  in  1  product consumed when res_valid && res_ready
- res_data  out  64  product, mod 2^64
- err_seq  out  1  sticky; pp_last disagreed with the internal row count

## Operation
- States: IDLE, ACCUM, DONE.
  - IDLE: pp_ready=1, acc=0, row counter=0.
  - First accepted row moves to ACCUM.
  - ACCUM: pp_ready=1.
  - Accepting row NUM_PP-1 moves to DONE.
  - DONE: pp_ready=0, res_valid=1; a res handshake returns to IDLE.
- Row alignment, with row index i:
  - Row 0 is added at bit offset 0.
  - Row i≥1 is added at offset 2(i-1); its bits [1:0] carry the previous row's +1 correction.
  - The last row additionally adds pp_tail at offset 2(NUM_PP-1).
- Arithmetic: 64-bit, wrap modulo 2^64. Bits shifted beyond bit 63 are discarded. No sign handling is done here; the encoding makes the wrapped sum equal the product.
- The shift/add implementation is free (left-shifted add or right-shifting accumulator with a retire buffer), provided res_data matches the sum above.
- err_seq: set when a row is accepted with pp_last≠(counter==NUM_PP-1). The row is still processed by count; pp_last never ends a product early. Cleared only by rst_n.
- clear: highest priority in every state. Next state is IDLE with acc and counter zeroed and res_valid=0. err_seq is unaffected.
- res_data holds stable while res_valid=1 and res_ready=0.

## Timing
- Reset values: pp_ready=1, res_valid=0, res_data=0, err_seq=0, state IDLE.
- Throughput is one row per cycle while pp_valid=1.
- Latency: res_valid rises the cycle after row NUM_PP-1 is accepted.
- Minimum cycle per product is NUM_PP+1 clocks including the result handshake cycle.
- On a res handshake cycle, pp_ready stays 0; it rises the next cycle. No overlap between products.
- pp_valid while pp_ready=0 has no effect. The sender holds data per valid/ready rules.
- rst_n low mid-product discards everything asynchronously; outputs take reset values immediately.

## Structure
- Shared package (booth_pkg), holding:
  - PP_W=36 and RES_W=64
  - NUM_PP default
  - state enum {IDLE, ACCUM, DONE}
  - tail encodings TAIL_NONE=2'b00, TAIL_NEG=2'b01
- One sub-module is natural: booth_row_align. It is combinational and maps (pp_data, pp_tail, row index, is_last) to a 64-bit aligned addend. The FSM, counter, and accumulator register stay in booth_pp_accum.

## Test plan
- All 17 rows zero-digit: row 0 = 36'h4_0000_0000, rows 1..16 = 36'hC_0000_0000, tails 00 -> res_data=0, err_seq=0.
- Multiplicand 1 × multiplier 1: row 0 = 36'h4_0000_0001, rows 1..16 = 36'hC_0000_0000 -> res_data=1.
- Multiplicand 1 × multiplier 2:
  - Row 0 = 36'h3_FFFF_FFFD with tail 01.
  - Row 1 = 36'hC_0000_0005.
  - Rows 2..16 = 36'hC_0000_0000.
  - Expected: res_data=2.
- Backpressure: hold res_ready=0 for 5 cycles with pp_valid=1 -> pp_ready=0, res_data stable, no row consumed, result released on the first res_ready.
- Sequence error and abort:
  - pp_last=1 on row 3 -> err_seq=1 and stays 1; product still completes after 17 rows.
  - clear on row 8 -> IDLE next cycle; the following 17 rows give the correct product.
- Random: 10k random 32-bit unsigned operand pairs through a generator model with random pp_valid/res_ready gaps -> res_data == a*b mod 2^64 every time; asynchronous rst_n pulse mid-product restores the reset outputs.
